// File: rtl/prefetch_queue_ctrl_pkg.sv
// Shared opcodes, controller states and arbiter request indices for the
// prefetch queue controller.
package prefetch_ctrl_pkg;

  localparam logic [1:0] OP_INVALIDATE = 2'd0;
  localparam logic [1:0] OP_READ       = 2'd1;
  localparam logic [1:0] OP_WRITE_REQ  = 2'd2;
  localparam logic [1:0] OP_WRITE_RESP = 2'd3;

  // Request slots, lowest index wins the queue port.
  localparam int unsigned NumReq    = 4;
  localparam int unsigned ReqResp   = 0;
  localparam int unsigned ReqLookup = 1;
  localparam int unsigned ReqInv    = 2;
  localparam int unsigned ReqPf     = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WAIT_DATA,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/prefetch_queue_ctrl_if.sv
// Requester handshakes and queue port of the prefetch queue controller.
// master = controller side, slave = requesters/queue side.
interface prefetch_queue_ctrl_if #(
  parameter int unsigned LOG_QUEUE_SIZE       = 6,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
  parameter int unsigned BA_ADDR_SIZE         = 64
);
  localparam int unsigned DATA_W = 1 << LOG_BLOCK_DATA_BYTES;

  logic                      dReqValid;
  logic                      dReqReady;
  logic [BA_ADDR_SIZE-1:0]   dReqAddr;
  logic                      dRespValid;
  logic                      dRespHit;
  logic [DATA_W-1:0]         dRespData;

  logic                      rValid;
  logic                      rReady;
  logic [BA_ADDR_SIZE-1:0]   rAddr;
  logic [DATA_W-1:0]         rData;

  logic                      invValid;
  logic                      invReady;
  logic [BA_ADDR_SIZE-1:0]   invAddr;

  logic                      pfValid;
  logic                      pfReady;
  logic [BA_ADDR_SIZE-1:0]   pfAddr;

  logic                      qOpValid;
  logic [1:0]                qOpcode;
  logic [BA_ADDR_SIZE-1:0]   qAddr;
  logic [DATA_W-1:0]         qData;
  logic                      qValid;
  logic                      qDataValid;
  logic [DATA_W-1:0]         qDataOut;
  logic [LOG_QUEUE_SIZE:0]   qOutstandingCnt;
  logic                      qAlmostFull;

  logic                      flushReq;

  modport master (
    input  dReqValid, dReqAddr, rValid, rAddr, rData, invValid, invAddr, pfValid, pfAddr,
    input  qValid, qDataValid, qDataOut, qOutstandingCnt, qAlmostFull,
    output dReqReady, dRespValid, dRespHit, dRespData, rReady, invReady, pfReady,
    output qOpValid, qOpcode, qAddr, qData, flushReq
  );

  modport slave (
    output dReqValid, dReqAddr, rValid, rAddr, rData, invValid, invAddr, pfValid, pfAddr,
    output qValid, qDataValid, qDataOut, qOutstandingCnt, qAlmostFull,
    input  dReqReady, dRespValid, dRespHit, dRespData, rReady, invReady, pfReady,
    input  qOpValid, qOpcode, qAddr, qData, flushReq
  );

endinterface

// File: rtl/prefetch_queue_ctrl_arbiter.sv
// Fixed-priority grant of the single queue op slot: response > lookup read >
// invalidate > prefetch.
module prefetch_op_arbiter
  import prefetch_ctrl_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              op_valid_o,
  output logic [1:0]        opcode_o
);

  always_comb begin
    gnt_o    = '0;
    opcode_o = OP_INVALIDATE;
    if (req_i[ReqResp]) begin
      gnt_o[ReqResp] = 1'b1;
      opcode_o       = OP_WRITE_RESP;
    end else if (req_i[ReqLookup]) begin
      gnt_o[ReqLookup] = 1'b1;
      opcode_o         = OP_READ;
    end else if (req_i[ReqInv]) begin
      gnt_o[ReqInv] = 1'b1;
      opcode_o      = OP_INVALIDATE;
    end else if (req_i[ReqPf]) begin
      gnt_o[ReqPf] = 1'b1;
      opcode_o     = OP_WRITE_REQ;
    end
  end

  assign op_valid_o = |gnt_o;

endmodule

// File: rtl/prefetch_queue_ctrl.sv
// Serialises DRAM responses, demand lookups, invalidates and prefetches onto the
// prefetch data queue and runs the demand-lookup state machine.
module prefetch_queue_ctrl
  import prefetch_ctrl_pkg::*;
#(
  parameter int unsigned LOG_QUEUE_SIZE       = 6,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
  parameter int unsigned BA_ADDR_SIZE         = 64,
  parameter int unsigned MAX_OUTSTANDING      = 16,
  parameter int unsigned WAIT_CNT_SIZE        = 8
) (
  input logic                   clk,
  input logic                   resetN,
  prefetch_queue_ctrl_if.master bus
);

  localparam int unsigned DATA_W = 1 << LOG_BLOCK_DATA_BYTES;
  localparam int unsigned CntW   = LOG_QUEUE_SIZE + 1;
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);

  ctrl_state_t              state_q;
  logic                     live_q;
  logic [BA_ADDR_SIZE-1:0]  addr_q;
  logic [DATA_W-1:0]        data_q;
  logic                     hit_q;
  logic                     resp_valid_q;
  logic                     flush_q;
  logic [WAIT_CNT_SIZE-1:0] wait_cnt_q;
  logic [WAIT_CNT_SIZE-1:0] wait_cnt_d;

  logic                     slot_busy;
  logic                     d_req_ready;
  logic                     inv_ready;
  logic                     pf_ready;
  logic                     resp_accept;
  logic [NumReq-1:0]        req;
  logic [NumReq-1:0]        gnt;
  logic                     op_valid;
  logic [1:0]               opcode;
  logic [BA_ADDR_SIZE-1:0]  q_addr;
  logic [DATA_W-1:0]        q_data;

  // live_q keeps every ready and op low until the first clock after reset.
  assign resp_accept = live_q & bus.rValid;
  assign slot_busy   = bus.rValid | (state_q == LOOKUP);
  assign d_req_ready = live_q & (state_q == IDLE);
  assign inv_ready   = live_q & ~slot_busy;
  assign pf_ready    = live_q & ~slot_busy & ~bus.invValid & ~bus.qAlmostFull &
                       (bus.qOutstandingCnt < MaxOut);
  assign wait_cnt_d  = wait_cnt_q + WAIT_CNT_SIZE'(1);

  assign req[ReqResp]   = resp_accept;
  assign req[ReqLookup] = live_q & (state_q == LOOKUP);
  assign req[ReqInv]    = live_q & bus.invValid;
  assign req[ReqPf]     = pf_ready & bus.pfValid;

  prefetch_op_arbiter u_arbiter (
    .req_i      (req),
    .gnt_o      (gnt),
    .op_valid_o (op_valid),
    .opcode_o   (opcode)
  );

  always_comb begin
    q_addr = '0;
    q_data = '0;
    if (gnt[ReqResp]) begin
      q_addr = bus.rAddr;
      q_data = bus.rData;
    end else if (gnt[ReqLookup]) begin
      q_addr = addr_q;
    end else if (gnt[ReqInv]) begin
      q_addr = bus.invAddr;
    end else if (gnt[ReqPf]) begin
      q_addr = bus.pfAddr;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      live_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      hit_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      live_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.dReqValid && d_req_ready) begin
            addr_q  <= bus.dReqAddr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          // A response owns the slot this cycle; retry the read next cycle.
          if (!bus.rValid) begin
            if (bus.qValid && bus.qDataValid) begin
              hit_q        <= 1'b1;
              data_q       <= bus.qDataOut;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else if (bus.qValid) begin
              wait_cnt_q <= '0;
              state_q    <= WAIT_DATA;
            end else begin
              hit_q        <= 1'b0;
              data_q       <= '0;
              resp_valid_q <= 1'b1;
              flush_q      <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        WAIT_DATA: begin
          wait_cnt_q <= wait_cnt_d;
          // Timer saturation rechecks in case the entry was evicted.
          if ((resp_accept && (bus.rAddr == addr_q)) || (wait_cnt_d == '1)) begin
            state_q <= LOOKUP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.dReqReady  = d_req_ready;
  assign bus.dRespValid = resp_valid_q;
  assign bus.dRespHit   = hit_q;
  assign bus.dRespData  = data_q;
  assign bus.rReady     = live_q;
  assign bus.invReady   = inv_ready;
  assign bus.pfReady    = pf_ready;
  assign bus.qOpValid   = op_valid;
  assign bus.qOpcode    = opcode;
  assign bus.qAddr      = q_addr;
  assign bus.qData      = q_data;
  assign bus.flushReq   = flush_q;

endmodule
